instruction_decode: RTL and testbench

Decode stage directly downstream of the instruction fetch stage. It accepts one 32-bit instruction per valid/ready handshake and splits it into opcode, destination and immediate fields. It reads up to two source operands through the 16-entry, 16-bit register file's single read port, sequencing the two reads. It then presents one decoded bundle to the execute stage under a valid/ready handshake.

---
 rtl/instruction_decode.sv | 138 +++++++++++++
 tb/tb_instruction_decode.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// Decode stage: latches one instruction, sequences up to two register-file
// reads over a single read port, and presents a registered decoded bundle.
module instruction_decode #(
  parameter int INSTR_WIDTH  = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int REG_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INSTR_WIDTH-1:0]  instruction,
  output logic                    reg_rd,
  output logic [REG_ID_WIDTH-1:0] reg_id,
  input  logic [DATA_WIDTH-1:0]   read_data_reg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              opcode,
  output logic [REG_ID_WIDTH-1:0] dest_id,
  output logic [DATA_WIDTH-1:0]   operand_a,
  output logic [DATA_WIDTH-1:0]   operand_b,
  output logic [DATA_WIDTH-1:0]   imm,
  output logic                    write_en,
  output logic                    illegal,
  output logic                    halted
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RA   = 3'd1;
  localparam logic [2:0] S_RB   = 3'd2;
  localparam logic [2:0] S_CA   = 3'd3;
  localparam logic [2:0] S_CB   = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  logic [2:0]              state;
  logic [REG_ID_WIDTH-1:0] rs2;
  logic                    need_b;

  logic [3:0]              in_op;
  logic                    in_rd1, in_rd2, in_we, in_ill;

  // Class decode of the word on the fetch bus; only consumed on accept.
  always_comb begin
    in_op  = instruction[31:28];
    in_rd2 = (in_op >= 4'h1 && in_op <= 4'h5) || in_op == 4'h8 || in_op == 4'h9;
    in_rd1 = in_rd2 || in_op == 4'h6 || in_op == 4'h7;
    in_we  = (in_op >= 4'h1 && in_op <= 4'h7) || in_op == 4'hB;
    in_ill = in_op == 4'hC || in_op == 4'hD || in_op == 4'hE;
  end

  // Outputs are loaded from the next state so every port is a flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      reg_rd    <= 1'b0;
      reg_id    <= '0;
      out_valid <= 1'b0;
      opcode    <= '0;
      dest_id   <= '0;
      operand_a <= '0;
      operand_b <= '0;
      imm       <= '0;
      write_en  <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
      rs2       <= '0;
      need_b    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          opcode    <= in_op;
          dest_id   <= instruction[27:24];
          imm       <= instruction[15:0];
          write_en  <= in_we;
          illegal   <= in_ill;
          rs2       <= instruction[19:16];
          need_b    <= in_rd2;
          in_ready  <= 1'b0;
          operand_a <= '0;
          operand_b <= (in_rd1 || in_ill) ? '0 : instruction[15:0];
          if (in_rd1) begin
            state  <= S_RA;
            reg_rd <= 1'b1;
            reg_id <= instruction[23:20];
          end else begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end
        end
        S_RA: begin
          if (need_b) begin
            state  <= S_RB;
            reg_id <= rs2;
          end else begin
            state  <= S_CA;
            reg_rd <= 1'b0;
            reg_id <= '0;
          end
        end
        S_RB: begin
          operand_a <= read_data_reg;
          reg_rd    <= 1'b0;
          reg_id    <= '0;
          state     <= S_CB;
        end
        S_CA: begin
          operand_a <= read_data_reg;
          operand_b <= imm;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_CB: begin
          operand_b <= read_data_reg;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (opcode == 4'hF) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_HALT: ;
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed scenarios plus random
// instructions against a field-level reference model and register-file model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic        reg_rd;
  logic [3:0]  reg_id;
  logic [15:0] read_data_reg = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  opcode, dest_id;
  logic [15:0] operand_a, operand_b, imm;
  logic        write_en, illegal, halted;

  instruction_decode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .reg_rd(reg_rd), .reg_id(reg_id),
    .read_data_reg(read_data_reg), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .dest_id(dest_id), .operand_a(operand_a),
    .operand_b(operand_b), .imm(imm), .write_en(write_en), .illegal(illegal),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] im;
    logic        we;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic [15:0] regs [16];
  exp_t        exp_q [$];
  logic [3:0]  rd_q [$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: data answers the strobe one cycle later; junk otherwise.
  logic [15:0] rd_nxt = '0;
  always @(negedge clk) rd_nxt = reg_rd ? regs[reg_id] : 16'($urandom);
  always @(posedge clk) read_data_reg <= rd_nxt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: operand sources follow the opcode class table.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [3:0] op;
    bit two, one;
    op    = ins[31:28];
    two   = op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9};
    one   = two || op inside {4'h6, 4'h7};
    e.op  = op;
    e.rd  = ins[27:24];
    e.im  = ins[15:0];
    e.ill = op inside {4'hC, 4'hD, 4'hE};
    e.we  = op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hB};
    e.a   = one ? regs[ins[23:20]] : 16'h0;
    e.b   = two ? regs[ins[19:16]] : (e.ill ? 16'h0 : ins[15:0]);
    e.lat = two ? 4 : (one ? 3 : 1);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: all sampling on the falling edge.
  bit          seen_v = 0, stall_prev = 0, hs_prev = 0;
  logic [3:0]  hs_op;
  logic [57:0] held;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      rd_q.delete();
      seen_v = 0; stall_prev = 0; hs_prev = 0;
    end else begin
      if (hs_prev) begin
        chk("post_hs_out_valid", out_valid, 0);
        if (hs_op == 4'hF) begin
          chk("post_hs_halted", halted, 1);
          chk("post_hs_in_ready", in_ready, 0);
        end else
          chk("post_hs_in_ready", in_ready, 1);
        hs_prev = 0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(instruction);
        e.acc = cyc;
        exp_q.push_back(e);
        if (e.lat >= 3) rd_q.push_back(instruction[23:20]);
        if (e.lat == 4) rd_q.push_back(instruction[19:16]);
      end
      if (reg_rd) begin
        if (rd_q.size() == 0) chk("spurious_read", 1, 0);
        else chk("reg_id", reg_id, rd_q.pop_front());
      end else
        chk("reg_id_idle", reg_id, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_bundle", 1, 0);
        else begin
          if (!seen_v) begin
            seen_v = 1;
            chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
          end
          if (stall_prev)
            chk("stall_stable", {opcode, dest_id, operand_a, operand_b, imm, write_en, illegal}, held);
          chk("in_ready_busy", in_ready, 0);
          if (out_ready) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("opcode", opcode, e.op);
            chk("dest_id", dest_id, e.rd);
            chk("operand_a", operand_a, e.a);
            chk("operand_b", operand_b, e.b);
            chk("imm", imm, e.im);
            chk("write_en", write_en, e.we);
            chk("illegal", illegal, e.ill);
            seen_v = 0;
            hs_prev = 1;
            hs_op = opcode;
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {opcode, dest_id, operand_a, operand_b, imm, write_en, illegal};
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] ins);
    bit acc = 0;
    in_valid = 1'b1;
    instruction = ins;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk) acc = in_ready;
      step();
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    instruction = $urandom;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) step();
    chk("drain_timeout", 64'(exp_q.size()), 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    regs[1] = 16'h0011; regs[2] = 16'h0022; regs[5] = 16'h00A5;
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_reg_rd", reg_rd, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bundle", {opcode, dest_id, operand_a, operand_b, imm, write_en, illegal}, 0);

    out_ready = 1'b1;
    send(32'h13120000); wait_done();   // ADD r3,r1,r2
    send(32'h64501234); wait_done();   // ADDI r4,r5,0x1234
    send(32'hA0000040); wait_done();   // JMP
    send(32'hC0000000); wait_done();   // illegal

    // STORE stalled for 5 cycles
    out_ready = 1'b0;
    send(32'h80120000);
    for (int k = 0; k < 20 && !out_valid; k++) step();
    chk("store_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", out_valid, 0);
    wait_done();

    // Reset during RB of an ADD
    send(32'h13120000);
    for (int k = 0; k < 10 && !(reg_rd && reg_id == 4'd2); k++) step();
    chk("reached_rb", {reg_rd, reg_id}, {1'b1, 4'd2});
    reset = 1'b0;
    step();
    chk("abort_reg_rd", reg_rd, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("abort_no_bundle", out_valid, 0);
      step();
    end

    // Random traffic, random back-pressure, no HALT
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 14));
      send({op, 28'($urandom)});
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end
    wait_done();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    step();

    // HALT
    send(32'hF0000000); wait_done();
    in_valid = 1'b1;
    instruction = 32'h13120000;
    for (int k = 0; k < 20; k++) begin
      chk("halt_halted", halted, 1);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_out_valid", out_valid, 0);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("unhalt_halted", halted, 0);
    chk("unhalt_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
